sram_like_resp: RTL



---
 rtl/mycpu_pkg.sv | 32 +++
 rtl/sram_like_resp_fifo.sv | 64 ++++++
 rtl/sram_like_resp.sv | 95 +++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared SRAM-like bus definitions for the core ports and memory models.
// Also holds the response-queue entry layout used by sram_like_resp.
package mycpu_pkg;

  localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  localparam int SRAM_REQ_W = $bits(sram_req_t);

  localparam int RESP_MAXQ = 8;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [2:0]  timer;
  } resp_entry_t;

  function automatic logic [2:0] tick(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: circular buffer of entries with a
// per-entry countdown; the head is ready once its timer hits zero.
module resp_fifo
  import mycpu_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_ready,
  output logic        head_wr,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count
);

  localparam logic [2:0] LAST  = 3'(QDEPTH - 1);
  localparam logic [2:0] T0    = 3'(LATENCY - 1);
  localparam logic [3:0] DEPTH = 4'(QDEPTH);

  resp_entry_t ent [RESP_MAXQ];
  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  // pointers and occupancy; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + {3'b0, push} - {3'b0, pop};
    end
  end

  // entry payloads: timers count down, a push loads a fresh entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < RESP_MAXQ; i++) begin
      ent[i].timer <= tick(ent[i].timer);
      if (push && wr_ptr == 3'(i)) begin
        ent[i] <= '{is_wr: push_wr, data: push_data, timer: T0};
      end
    end
  end

  assign empty      = (count == 4'd0);
  assign full       = (count == DEPTH);
  assign head_ready = !empty && (ent[rd_ptr].timer == 3'd0);
  assign head_wr    = ent[rd_ptr].is_wr;
  assign head_data  = ent[rd_ptr].data;

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like slave memory model: word array with byte-strobe writes,
// fixed response latency and an in-order outstanding queue.
module sram_like_resp
  import mycpu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [3:0]  outstanding
);

  if (LATENCY < 1 || LATENCY > 8 ||
      QDEPTH < 1 || QDEPTH > 8 ||
      ADDR_W < 1 || ADDR_W > 29) begin : g_bad_param
    $error("sram_like_resp: parameter out of range");
  end

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              reset_d;
  logic              accept;
  logic              full;
  logic              empty;
  logic              head_ready;
  logic              head_wr;
  logic [31:0]       head_data;
  logic [31:0]       resp_word;
  logic [31:0]       rdata_q;
  logic              unused_bits;

  assign idx       = addr[ADDR_W+1:2];
  assign addr_ok   = !reset && !reset_d && !full;
  assign accept    = req && addr_ok;
  assign data_ok   = !reset && head_ready;
  assign resp_word = head_wr ? 32'h0 : head_data;
  assign rdata     = data_ok ? resp_word : rdata_q;

  assign unused_bits = ^{addr[1:0], addr[31:ADDR_W+2], size, empty};

  // delayed reset keeps addr_ok low for one cycle after release
  always_ff @(posedge clk) begin
    reset_d <= reset;
  end

  // rdata holds the last response between data_ok pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (data_ok) begin
      rdata_q <= resp_word;
    end
  end

  // byte-strobe write into the word array; contents survive reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  resp_fifo #(
    .QDEPTH (QDEPTH),
    .LATENCY(LATENCY)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_wr   (wr),
    .push_data (mem[idx]),
    .pop       (data_ok),
    .head_ready(head_ready),
    .head_wr   (head_wr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

endmodule
